// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the NPC front end: opcodes, NOP encoding, reset PC, IFU states.
package ysyx_24110006_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned RESP_W = 2;

    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP     = 7'b0110011;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_PEND  = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24110006_ifu_if.sv
// AXI4-Lite-style read channel between the IFU (master) and instruction memory (slave).
//  araddr/arvalid/arready : read address channel
//  rdata/rresp/rvalid/rready : read data channel
interface ysyx_24110006_ifu_if;
    import ysyx_24110006_pkg::*;

    logic [XLEN-1:0]   araddr;
    logic              arvalid;
    logic              arready;
    logic [XLEN-1:0]   rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_24110006_immgen.sv
// Combinational immediate generator: sign-extended immediate selected by opcode.
//  inst : instruction word
//  imm  : immediate (0 for opcodes without one)
module ysyx_24110006_immgen
    import ysyx_24110006_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        unique case (inst[OPC_W-1:0])
            OP_IMM, LOAD, JALR, SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            LUI, AUIPC:
                imm = {inst[31:12], 12'h000};
            JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            // funct7 exposed for R-type so decode can read it from the same bus
            OP:
                imm = {25'b0, inst[31:25]};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch stage: holds PC, issues one read per instruction, hands
// inst/imm/pc to decode, then waits for write-back to supply the next PC.
//  i_clock, i_reset : clock, synchronous active-low reset
//  rd               : read channel (master side)
//  o_inst/o_imm/o_pc/o_fetch_err/o_valid, i_ready : decode handshake
//  i_pc_wen/i_dnpc  : next PC from write-back
module ysyx_24110006_ifu
    import ysyx_24110006_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    ysyx_24110006_ifu_if.master     rd,
    output logic [XLEN-1:0]         o_inst,
    output logic [XLEN-1:0]         o_imm,
    output logic [XLEN-1:0]         o_pc,
    output logic                    o_fetch_err,
    output logic                    o_valid,
    input  logic                    i_ready,
    input  logic                    i_pc_wen,
    input  logic [XLEN-1:0]         i_dnpc
);

    ifu_state_e      state;
    ifu_state_e      state_next;
    logic [XLEN-1:0] pc;

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   if (rd.arready) state_next = S_WAIT;
            S_WAIT:  if (rd.rvalid)  state_next = S_VALID;
            S_VALID: if (i_ready)    state_next = S_PEND;
            S_PEND:  if (i_pc_wen)   state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        rd.arvalid = 1'b0;
        rd.rready  = 1'b0;
        o_valid    = 1'b0;
        unique case (state)
            S_REQ:   rd.arvalid = 1'b1;
            S_WAIT:  rd.rready  = 1'b1;
            S_VALID: o_valid    = 1'b1;
            default: ;
        endcase
    end

    assign rd.araddr = pc;

    // PC and fetched-instruction registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            pc          <= RESET_PC;
            o_inst      <= NOP_INST;
            o_pc        <= RESET_PC;
            o_fetch_err <= 1'b0;
        end else begin
            if (state == S_WAIT && rd.rvalid) begin
                o_inst      <= rd.rdata;
                o_pc        <= pc;
                o_fetch_err <= (rd.rresp != '0);
            end
            // Instruction addresses are word aligned; low bits are dropped
            if (state == S_PEND && i_pc_wen) begin
                pc <= i_dnpc & ~XLEN'(3);
            end
        end
    end

    ysyx_24110006_immgen u_immgen (
        .inst (o_inst),
        .imm  (o_imm)
    );

endmodule
